// File: rtl/axis_capture_sink_if.sv
// AXI4-Stream sample channel between a stream source and the capture sink.
// Beat layout is {Q[TWID-1:0], I[TWID-1:0]}.
interface axis_capture_sink_if #(
    parameter int TWID = 16
);
    logic [2*TWID-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_capture_sink.sv
// AXI4-Stream capture sink: arm + trigger, then store a programmable-length burst; sync read port.
// Latency: capture starts the cycle after trig, rd_data is 1 cycle after rd_addr; tready is registered.
// Backpressure: tready only in CAPTURE (pseudo-random when CAPTURE_THROTTLE_EN is defined); ignored beats count as overrun.
module axis_capture_sink #(
    parameter  int TWID  = 16,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_arm,
    input  logic                 i_trig,
    input  logic [AW:0]          i_len,
    axis_capture_sink_if.slave   s_axis,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [AW:0]          o_wr_count,
    output logic [15:0]          o_overrun,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [2*TWID-1:0]    o_rd_data
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t              r_state;
    logic                r_tready;
    logic                r_busy;
    logic                r_done;
    logic [AW:0]         r_wr_count;
    logic [AW:0]         r_len_q;
    logic [15:0]         r_overrun;
    logic [2*TWID-1:0]   r_mem [DEPTH];
    logic [2*TWID-1:0]   r_rd_data;

    logic                w_hs;
    logic                w_last;
    logic [AW:0]         w_len_clamped;
    logic                w_thr_now;
    logic                w_thr_next;
    logic                w_rearm;

    assign w_len_clamped = ((i_len == '0) || (i_len > DEPTH_W)) ? DEPTH_W : i_len;
    assign w_hs          = s_axis.tvalid & r_tready;
    assign w_last        = w_hs & (r_wr_count == (r_len_q - ONE_W));
    assign w_rearm       = i_arm & ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef CAPTURE_THROTTLE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Fibonacci taps 16,14,13,11; seed reload on arm keeps backpressure repeatable per burst.
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_thr_now  = r_lfsr[0];
    assign w_thr_next = w_lfsr_nxt[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_rearm) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == S_CAPTURE) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_thr_now  = 1'b1;
    assign w_thr_next = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_count <= '0;
            r_len_q    <= DEPTH_W;
            r_overrun  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_arm) begin
                        r_state    <= S_ARMED;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_len_q    <= w_len_clamped;
                        r_wr_count <= '0;
                        r_overrun  <= '0;
                    end
                end
                S_ARMED: begin
                    if (i_trig) begin
                        r_state  <= S_CAPTURE;
                        r_tready <= w_thr_now;
                    end
                end
                S_CAPTURE: begin
                    r_tready <= w_thr_next;
                    if (w_hs) begin
                        r_wr_count <= r_wr_count + ONE_W;
                    end
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_tready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                    if (s_axis.tvalid && !r_tready && (r_overrun != 16'hFFFF)) begin
                        r_overrun <= r_overrun + 16'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tready <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Buffer has no reset so a partial burst survives rst for post-mortem readback.
    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            r_mem[r_wr_count[AW-1:0]] <= s_axis.tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign s_axis.tready = r_tready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_wr_count    = r_wr_count;
    assign o_overrun     = r_overrun;
    assign o_rd_data     = r_rd_data;
endmodule

// File: tb/tb_axis_capture_sink.sv
// Directed bench for axis_capture_sink: model-driven scoreboard of captured beats, readback compare.
module tb_axis_capture_sink;
    localparam int TWID  = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            rst;
    logic            arm;
    logic            trig;
    logic [AW:0]     len;
    logic            busy;
    logic            done;
    logic [AW:0]     wr_count;
    logic [15:0]     overrun;
    logic [AW-1:0]   rd_addr;
    logic [31:0]     rd_data;

    always #5 clk = ~clk;

    axis_capture_sink_if #(.TWID(TWID)) axis ();

    axis_capture_sink #(.TWID(TWID), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_arm      (arm),
        .i_trig     (trig),
        .i_len      (len),
        .s_axis     (axis),
        .o_busy     (busy),
        .o_done     (done),
        .o_wr_count (wr_count),
        .o_overrun  (overrun),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    int          n_vec   = 0;
    int          n_err   = 0;
    int          src_n   = 0;
    int          exp_ovr = 0;
    logic [31:0] exp_q[$];
    int          cyc_o;
    int          acc_o;
    int          ovr_run1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Arm with length l, then trigger; returns with the DUT in its first CAPTURE cycle.
    task automatic start(input int l);
        arm = 1'b1;
        len = (AW+1)'(l);
        tick();
        arm = 1'b0;
        check("armed_busy", busy, 1);
        check("armed_tready", axis.tready, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Free-running ramp source (ignores tready); model decides which beats the sink takes.
    task automatic run_capture(input int n_len, input bit alt, input bit arm_at0,
                               input int budget, output int cycles, output int acc);
        logic [15:0] m;
        logic [31:0] d;
        bit thr;
        bit v;
        int cnt;
        int cyc;
        m = SEED;
        cnt = 0;
        cyc = 0;
        exp_ovr = 0;
        while (cnt < n_len && cyc < budget) begin
`ifdef CAPTURE_THROTTLE_EN
            thr = m[0];
`else
            thr = 1'b1;
`endif
            check("tready", axis.tready, thr);
            check("done_early", done, 0);
            check("wr_count_trk", wr_count, cnt);
            v = alt ? (cyc % 2 == 0) : 1'b1;
            d = {16'(-src_n), 16'(src_n)};
            axis.tvalid = v;
            axis.tdata  = d;
            if (arm_at0 && cyc == 0) begin
                arm = 1'b1;
                len = (AW+1)'(2);
            end
            tick();
            arm = 1'b0;
            if (v) begin
                if (thr) begin
                    exp_q.push_back(d);
                    cnt++;
                end else begin
                    exp_ovr++;
                end
                src_n++;
            end
            m = lfsr_step(m);
            cyc++;
        end
        axis.tvalid = 1'b0;
        cycles = cyc;
        acc = cnt;
    endtask

    task automatic finish_checks(input int n_len, input int acc);
        check("accepted_in_budget", acc, n_len);
        check("done", done, 1);
        check("busy_after", busy, 0);
        check("tready_after", axis.tready, 0);
        check("wr_count", wr_count, n_len);
        check("overrun", overrun, exp_ovr);
    endtask

    task automatic readback();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            tick();
            check("rd_data", rd_data, exp_q.pop_front());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        trig = 1'b0;
        len = '0;
        rd_addr = '0;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tready", axis.tready, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        // trig in IDLE is ignored
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("idle_trig_busy", busy, 0);
        check("idle_trig_tready", axis.tready, 0);

        // arm+trig together: ARMED only, trig not seen
        arm = 1'b1;
        trig = 1'b1;
        len = (AW+1)'(8);
        tick();
        arm = 1'b0;
        trig = 1'b0;
        check("armtrig_busy", busy, 1);
        tick();
        check("armtrig_tready", axis.tready, 0);
        check("armtrig_busy2", busy, 1);

        // arm while ARMED must not relatch len
        arm = 1'b1;
        len = (AW+1)'(3);
        tick();
        arm = 1'b0;
        check("rearm_busy", busy, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;

        // basic ramp capture of 8 beats
        run_capture(8, 1'b0, 1'b0, 100, cyc_o, acc_o);
`ifndef CAPTURE_THROTTLE_EN
        check("len8_latency", cyc_o, 8);
`endif
        finish_checks(8, acc_o);
        readback();

        // trig in DONE is ignored
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("done_trig_done", done, 1);
        check("done_trig_busy", busy, 0);
        check("done_trig_wr", wr_count, 8);

        // alternating tvalid, with an arm pulse during CAPTURE
        start(4);
        run_capture(4, 1'b1, 1'b1, 100, cyc_o, acc_o);
        finish_checks(4, acc_o);
        readback();

        // len=0 means full depth; a further beat after done must be refused
        start(0);
        run_capture(DEPTH, 1'b0, 1'b0, 4000, cyc_o, acc_o);
        finish_checks(DEPTH, acc_o);
        axis.tvalid = 1'b1;
        axis.tdata = 32'hDEAD_BEEF;
        tick();
        axis.tvalid = 1'b0;
        check("extra_wr_count", wr_count, DEPTH);
        check("extra_tready", axis.tready, 0);
        check("extra_overrun", overrun, exp_ovr);
        readback();

        // reset in the middle of a 16-beat capture
        start(16);
        run_capture(16, 1'b0, 1'b0, 3, cyc_o, acc_o);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_tready", axis.tready, 0);
        check("midrst_done", done, 0);
        check("midrst_wr_count", wr_count, 0);
        check("midrst_rd_data", rd_data, 0);
        tick();
        readback();

        // free-running source, len=64, twice: overrun must track the model each run
        start(64);
        run_capture(64, 1'b0, 1'b0, 1000, cyc_o, acc_o);
        finish_checks(64, acc_o);
        ovr_run1 = exp_ovr;
        readback();
        start(64);
        run_capture(64, 1'b0, 1'b0, 1000, cyc_o, acc_o);
        finish_checks(64, acc_o);
        check("overrun_repeat", overrun, ovr_run1);
        readback();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
